// File: rtl/test_runner.sv
// ---------------------------------------------------------------------------
// test_runner
//
// Sequences a bank of N_TESTS self-test fixtures one after another. After a
// start-up delay it strobes each fixture's run line, waits for the fixture to
// go busy and then idle again, and samples its pass flag. The first failing
// fixture ends the sequence in FAIL; if every fixture passes it ends in PASS.
// Both end states hold until reset. Three LED requests show progress:
// blue blinks while busy, green means pass, red means fail.
//
// Optional feature (macro TEST_RUNNER_TIMEOUT_EN): a watchdog that fails the
// sequence when a fixture spends too long in ARM+RUN. Without the macro the
// watchdog is absent, o_timeout is tied low and ARM/RUN wait indefinitely.
//
// Parameters
//   N_TESTS      number of fixtures (1..16)
//   START_BITS   start-up delay of 2^START_BITS cycles
//   BLINK_BITS   blink counter width; blue toggles every 2^(BLINK_BITS-1)
//   TIMEOUT_BITS watchdog counter width (watchdog builds only)
//
// Ports
//   i_clk        system clock, rising edge
//   i_rst        asynchronous active-high reset
//   o_run        one-hot, one-cycle start strobe per fixture
//   i_running    per-fixture busy flag (only lane idx is observed)
//   i_passed     per-fixture result, valid while its i_running is low
//   o_busy       sequence in progress
//   o_done       sequence finished (pass or fail)
//   o_pass       every fixture passed
//   o_fail_idx   index of the first failing fixture
//   o_timeout    the failure came from the watchdog
//   o_led_r/g/b  LED PWM requests
// ---------------------------------------------------------------------------
module test_runner #(
  parameter int N_TESTS      = 4,
  parameter int START_BITS   = 6,
  parameter int BLINK_BITS   = 22,
  parameter int TIMEOUT_BITS = 24
) (
  input  logic               i_clk,
  input  logic               i_rst,
  output logic [N_TESTS-1:0] o_run,
  input  logic [N_TESTS-1:0] i_running,
  input  logic [N_TESTS-1:0] i_passed,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_pass,
  output logic [3:0]         o_fail_idx,
  output logic               o_timeout,
  output logic               o_led_r,
  output logic               o_led_g,
  output logic               o_led_b
);

  typedef enum logic [2:0] {
    S_WAIT,
    S_START,
    S_ARM,
    S_RUN,
    S_NEXT,
    S_PASS,
    S_FAIL
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              idx_q, idx_d;
  logic [START_BITS-1:0]   start_cnt_q, start_cnt_d;
  logic [BLINK_BITS-1:0]   blink_q;
  logic [N_TESTS-1:0]      run_q, run_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    pass_q, pass_d;
  logic [3:0]              fail_idx_q, fail_idx_d;
  logic [N_TESTS-1:0]      lane_sel;
  logic                    run_bit;
  logic                    pass_bit;
`ifdef TEST_RUNNER_TIMEOUT_EN
  logic [TIMEOUT_BITS-1:0] wdog_q, wdog_d;
  logic                    timeout_q, timeout_d;
`endif

  // Select only the active fixture's lane; all other lanes are don't-care.
  always_comb begin
    lane_sel = '0;
    for (int i = 0; i < N_TESTS; i++) begin
      lane_sel[i] = (idx_q == 4'(i));
    end
    run_bit  = |(i_running & lane_sel);
    pass_bit = |(i_passed & lane_sel);
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    start_cnt_d = start_cnt_q;
    fail_idx_d  = fail_idx_q;
`ifdef TEST_RUNNER_TIMEOUT_EN
    wdog_d      = wdog_q;
    timeout_d   = timeout_q;
`endif

    case (state_q)
      S_WAIT: begin
        if (&start_cnt_q) state_d = S_START;
        else              start_cnt_d = start_cnt_q + 1'b1;
      end
      S_START: state_d = S_ARM;
      S_ARM: begin
        if (run_bit) state_d = S_RUN;
      end
      S_RUN: begin
        if (!run_bit) begin
          if (pass_bit) begin
            state_d = S_NEXT;
          end else begin
            state_d    = S_FAIL;
            fail_idx_d = idx_q;
          end
        end
      end
      S_NEXT: begin
        if (idx_q == 4'(N_TESTS - 1)) begin
          state_d = S_PASS;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = S_START;
        end
      end
      default: ;  // PASS and FAIL hold until reset
    endcase

`ifdef TEST_RUNNER_TIMEOUT_EN
    // A fixture that finishes in the same cycle the watchdog would expire
    // keeps its genuine result; the watchdog only fires while still waiting.
    if (state_q == S_START) begin
      wdog_d = '0;
    end else if (state_q == S_ARM || state_q == S_RUN) begin
      wdog_d = wdog_q + 1'b1;
      if ((&wdog_d) && (state_d == S_ARM || state_d == S_RUN)) begin
        state_d    = S_FAIL;
        fail_idx_d = idx_q;
        timeout_d  = 1'b1;
      end
    end
`endif

    // Status outputs are registered from the next state so they line up with
    // the state register; the strobe is registered from the current START.
    busy_d = (state_d == S_START) || (state_d == S_ARM) ||
             (state_d == S_RUN)   || (state_d == S_NEXT);
    done_d = (state_d == S_PASS) || (state_d == S_FAIL);
    pass_d = (state_d == S_PASS);
    run_d  = (state_q == S_START) ? lane_sel : '0;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_WAIT;
      idx_q       <= '0;
      start_cnt_q <= '0;
      blink_q     <= '0;
      run_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_idx_q  <= '0;
`ifdef TEST_RUNNER_TIMEOUT_EN
      wdog_q      <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      start_cnt_q <= start_cnt_d;
      blink_q     <= blink_q + 1'b1;
      run_q       <= run_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_idx_q  <= fail_idx_d;
`ifdef TEST_RUNNER_TIMEOUT_EN
      wdog_q      <= wdog_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  assign o_run      = run_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_pass     = pass_q;
  assign o_fail_idx = fail_idx_q;
`ifdef TEST_RUNNER_TIMEOUT_EN
  assign o_timeout  = timeout_q;
`else
  assign o_timeout  = 1'b0;
`endif

  assign o_led_b = busy_q & blink_q[BLINK_BITS-1];
  assign o_led_g = pass_q;
  assign o_led_r = done_q & ~pass_q;

endmodule

// File: tb/tb_test_runner.sv
// ---------------------------------------------------------------------------
// Bench for test_runner: N_TESTS=4, START_BITS=3, BLINK_BITS=3,
// TIMEOUT_BITS=4. Expected strobes are queued as each scenario is set up and
// popped by a monitor whenever o_run is nonzero; status outputs are checked
// against constants at the end of each scenario.
// ---------------------------------------------------------------------------
module tb_test_runner;

  localparam int NT = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NT-1:0] run;
  logic [NT-1:0] running = '0;
  logic [NT-1:0] passed = '0;
  logic          busy, done, pass, timeout;
  logic [3:0]    fail_idx;
  logic          led_r, led_g, led_b;

  logic [NT-1:0] exp_q[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  int            cyc;

  test_runner #(
    .N_TESTS(NT), .START_BITS(3), .BLINK_BITS(3), .TIMEOUT_BITS(4)
  ) dut (
    .i_clk(clk), .i_rst(rst), .o_run(run), .i_running(running),
    .i_passed(passed), .o_busy(busy), .o_done(done), .o_pass(pass),
    .o_fail_idx(fail_idx), .o_timeout(timeout),
    .o_led_r(led_r), .o_led_g(led_g), .o_led_b(led_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Cycles since reset release: the blink counter model.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Strobe scoreboard and blue-LED model.
  always @(negedge clk) begin
    if (!rst) begin
      if (run != '0) begin
        if (exp_q.size() == 0) check("unexpected_strobe", run, 0);
        else                   check("strobe", run, exp_q.pop_front());
      end
      if (busy) check("led_b_blink", led_b, (cyc >> 2) & 1);
    end
  end

  task automatic check_idle_outputs(input string tag);
    check({tag, "_run"},   run, 0);
    check({tag, "_busy"},  busy, 0);
    check({tag, "_done"},  done, 0);
    check({tag, "_pass"},  pass, 0);
    check({tag, "_fidx"},  fail_idx, 0);
    check({tag, "_tmo"},   timeout, 0);
    check({tag, "_leds"},  {led_r, led_g, led_b}, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    running = '0;
    passed = '0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_strobe(input int k, output bit ok);
    int t = 0;
    ok = 1'b0;
    while (t < 200 && !ok) begin
      @(negedge clk);
      t++;
      ok = run[k];
    end
    if (!ok) check("strobe_timeout", t, 0);
  endtask

  // Fixture k: stray running on other lanes in the strobe cycle, then its own
  // running for 5 cycles; other lanes' passed carry the opposite result.
  task automatic drive_fixture(input int k, input bit p);
    bit ok;
    logic [NT-1:0] lane;
    lane = NT'(1) << k;
    wait_strobe(k, ok);
    if (ok) begin
      running = ~lane;
      passed  = p ? lane : ~lane;
      @(negedge clk);
      running = lane;
      repeat (5) @(negedge clk);
      running = '0;
    end
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!done) check("done_timeout", n, 0);
  endtask

  initial begin
    int n;
    bit ok;

    // Reset state.
    #1;
    check_idle_outputs("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("wait_leds", {led_r, led_g, led_b}, 0);
    check("wait_busy", busy, 0);

    // All four fixtures pass.
    do_reset();
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000);
    for (int k = 0; k < NT; k++) drive_fixture(k, 1'b1);
    wait_done(n);
    check("pass_done",  done, 1);
    check("pass_pass",  pass, 1);
    check("pass_led_g", led_g, 1);
    check("pass_led_r", led_r, 0);
    check("pass_busy",  busy, 0);
    repeat (6) @(negedge clk);
    check("pass_hold",  pass, 1);
    check("pass_queue", exp_q.size(), 0);

    // Fixture 2 fails; fixture 3 must never be strobed.
    do_reset();
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100);
    drive_fixture(0, 1'b1);
    drive_fixture(1, 1'b1);
    drive_fixture(2, 1'b0);
    wait_done(n);
    check("fail_idx",   fail_idx, 2);
    check("fail_led_r", led_r, 1);
    check("fail_led_g", led_g, 0);
    check("fail_pass",  pass, 0);
    check("fail_tmo",   timeout, 0);
    repeat (12) @(negedge clk);
    check("fail_done",  done, 1);
    check("fail_queue", exp_q.size(), 0);

    // Reset while fixture 1 is running.
    do_reset();
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0010);
    drive_fixture(0, 1'b1);
    wait_strobe(1, ok);
    passed = 4'b0010;
    @(negedge clk);
    running = 4'b0010;
    repeat (2) @(negedge clk);
    check("mid_busy_before", busy, 1);
    #1 rst = 1'b1;
    #1;
    check_idle_outputs("mid_reset");
    @(negedge clk);
    running = '0;
    exp_q.delete();
    exp_q.push_back(4'b0001);
    rst = 1'b0;
    n = 0;
    while (n < 40 && run == '0) begin
      @(negedge clk);
      n++;
    end
    check("rst_latency", n, 9);

`ifdef TEST_RUNNER_TIMEOUT_EN
    // Fixture 0 never responds: watchdog fires after 15 cycles in ARM.
    do_reset();
    exp_q.push_back(4'b0001);
    wait_strobe(0, ok);
    wait_done(n);
    check("wd_cycles",  n, 15);
    check("wd_timeout", timeout, 1);
    check("wd_fidx",    fail_idx, 0);
    check("wd_led_r",   led_r, 1);
`else
    // Fixture 0 never responds: ARM waits indefinitely.
    do_reset();
    exp_q.push_back(4'b0001);
    wait_strobe(0, ok);
    repeat (40) @(negedge clk);
    check("arm_busy",    busy, 1);
    check("arm_done",    done, 0);
    check("arm_timeout", timeout, 0);
`endif
    check("final_queue", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
